// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the frequency meter.
// Holds the FSM state enum and default gate/count widths.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GATE_CYCLES_DEF = 1000;
  localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchronizer plus rising-edge detector; pulse is 1 clk wide.
// Ports: clk, rst (async active-low), d (async input), pulse (output).
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic s1, s2, s3;
  logic v1, v2, v3;

  // v* track which stages hold sampled data since reset, so a
  // signal already high at release is not mistaken for an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
      v1 <= 1'b1;
      v2 <= v1;
      v3 <= v2;
    end
  end

  assign pulse = v3 & s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clks.
// Ports: clk, rst (async low), sig_in, start, ack -> count, valid, busy, ovf.
// Define FREQ_METER_CONTINUOUS_EN to restart the gate on ack.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             busy,
  output logic             ovf
);

  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] TLOAD = TW'(GATE_CYCLES - 1);

  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [CNT_W-1:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic wovf, wovf_n;
  logic ovf_q, ovf_n;
  logic edge_p;

  sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
    .pulse (edge_p)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      wcnt  <= '0;
      wovf  <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      wcnt  <= wcnt_n;
      wovf  <= wovf_n;
      cnt_q <= cnt_n;
      ovf_q <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    wcnt_n  = wcnt;
    wovf_n  = wovf;
    cnt_n   = cnt_q;
    ovf_n   = ovf_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = GATE;
          timer_n = TLOAD;
          wcnt_n  = '0;
          wovf_n  = 1'b0;
        end
      end
      GATE: begin
        if (edge_p) begin
          if (&wcnt) wovf_n = 1'b1;
          else       wcnt_n = wcnt + 1'b1;
        end
        // Latch the updated values so an edge in the last cycle counts.
        if (timer == '0) begin
          state_n = DONE;
          cnt_n   = wcnt_n;
          ovf_n   = wovf_n;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      DONE: begin
        if (ack) begin
`ifdef FREQ_METER_CONTINUOUS_EN
          state_n = GATE;
          timer_n = TLOAD;
          wcnt_n  = '0;
          wovf_n  = 1'b0;
`else
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign valid = (state == DONE);
  assign busy  = (state == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: gate length, counts, saturation,
// handshake and reset behaviour on a 16-bit and a 4-bit instance.
module tb_freq_meter;

  logic clk = 1'b0;
  logic rst;
  logic sig_a, start_a, ack_a;
  logic sig_b, start_b, ack_b;
  logic run_a, run_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;
  logic valid_a, busy_a, ovf_a;
  logic valid_b, busy_b, ovf_b;

  int checks = 0;
  int errors = 0;
  int nb;
  int nv;
  int rng;

  always #5 clk = ~clk;

  initial begin
    #3;
    forever begin
      #50;
      if (run_a) sig_a = ~sig_a;
    end
  end

  initial begin
    #7;
    forever begin
      #20;
      if (run_b) sig_b = ~sig_b;
    end
  end

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(16)) u0 (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_a),
    .start  (start_a),
    .ack    (ack_a),
    .count  (count_a),
    .valid  (valid_a),
    .busy   (busy_a),
    .ovf    (ovf_a)
  );

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(4)) u1 (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_b),
    .start  (start_b),
    .ack    (ack_b),
    .count  (count_b),
    .valid  (valid_b),
    .busy   (busy_b),
    .ovf    (ovf_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Counts busy cycles until valid; pokes start+ack mid-gate,
  // which must both be ignored.
  task automatic meas_a(output int n);
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      if (valid_a) break;
      if (busy_a) n++;
      start_a = (k == 500);
      ack_a   = (k == 500);
      @(negedge clk);
    end
    start_a = 1'b0;
    ack_a   = 1'b0;
  endtask

  task automatic meas_b(output int n);
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      if (valid_b) break;
      if (busy_b) n++;
      @(negedge clk);
    end
  endtask

  task automatic chk_rng(input string tag);
    rng = (count_a >= 16'd99 && count_a <= 16'd101) ? 100 : int'(count_a);
    check(tag, 32'(rng), 32'd100);
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
    run_a = 1'b0; run_b = 1'b0;
    sig_a = 1'b0; sig_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_ovf",   32'(ovf_a),   32'd0);
    check("rst_cnt_b", 32'(count_b), 32'd0);

    // sig_b already high at release: no edge may be counted
    rst = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    meas_b(nb);
    check("hi_busy",  32'(nb),      32'd1000);
    check("hi_valid", 32'(valid_b), 32'd1);
    check("hi_count", 32'(count_b), 32'd0);
    check("hi_ovf",   32'(ovf_b),   32'd0);

    // sig_a held low
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    meas_a(nb);
    check("lo_busy",  32'(nb),      32'd1000);
    check("lo_valid", 32'(valid_a), 32'd1);
    check("lo_count", 32'(count_a), 32'd0);
    check("lo_ovf",   32'(ovf_a),   32'd0);
    repeat (5) @(negedge clk);
    check("lo_hold",  32'(valid_a), 32'd1);

    // ack and start together: ack wins
    ack_a = 1'b1; start_a = 1'b1; run_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0; start_a = 1'b0;
    check("ack_valid", 32'(valid_a), 32'd0);
`ifdef FREQ_METER_CONTINUOUS_EN
    check("cont_busy1", 32'(busy_a), 32'd1);
    meas_a(nb);
    check("cont_nb1", 32'(nb), 32'd1000);
    chk_rng("cont_cnt1");
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    check("cont_busy2", 32'(busy_a), 32'd1);
`else
    check("ack_idle", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("start_drop", 32'(busy_a), 32'd0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
`endif
    meas_a(nb);
    check("f100_busy",  32'(nb),      32'd1000);
    check("f100_valid", 32'(valid_a), 32'd1);
    chk_rng("f100_count");
    check("f100_ovf",   32'(ovf_a),   32'd0);

    // 4-bit counter saturates at 250 edges
    run_b = 1'b1; ack_b = 1'b1;
    @(negedge clk);
    ack_b = 1'b0;
`ifndef FREQ_METER_CONTINUOUS_EN
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
`endif
    meas_b(nb);
    check("sat_busy",  32'(nb),      32'd1000);
    check("sat_count", 32'(count_b), 32'd15);
    check("sat_ovf",   32'(ovf_b),   32'd1);

    // reset mid-gate
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
`ifndef FREQ_METER_CONTINUOUS_EN
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
`endif
    repeat (500) @(negedge clk);
    check("mid_busy", 32'(busy_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_count", 32'(count_a), 32'd0);
    check("arst_valid", 32'(valid_a), 32'd0);
    check("arst_busy",  32'(busy_a),  32'd0);
    check("arst_ovf",   32'(ovf_a),   32'd0);
    check("arst_ovf_b", 32'(ovf_b),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    for (int k = 0; k < 1200; k++) begin
      if (valid_a || busy_a) nv++;
      @(negedge clk);
    end
    check("post_rst_idle", 32'(nv), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameters: GATE_CYCLES, 1000, gate window length in clk cycles (>=2).
REQ-002 The block SHALL have parameters: CNT_W, 16, width of the edge count result.
REQ-003 The block SHALL have ports: clk  input  1  reference clock, all state on rising edge.
REQ-004 The block SHALL have ports: rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports: sig_in  input  1  measured signal (divider freq50p), asynchronous to clk.
REQ-006 The block SHALL have ports: start  input  1  single-cycle request to begin a measurement.
REQ-007 The block SHALL have ports: ack  input  1  consumer acknowledge of a valid result.
REQ-008 The block SHALL have ports: count  output  CNT_W  sig_in rising edges counted in the last gate window.
REQ-009 The block SHALL have ports: valid  output  1  count holds an unacknowledged result.
REQ-010 The block SHALL have ports: busy  output  1  gate window in progress.
REQ-011 The block SHALL have ports: ovf  output  1  edge count saturated in the last window.

Function
REQ-012 sig_in SHALL pass a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle pulse edge_p.
REQ-013 The FSM SHALL have states IDLE, GATE, DONE; reset state IDLE.
REQ-014 IDLE: start=1 SHALL move to GATE next cycle, clear the working counter and ovf flag, and load gate timer with GATE_CYCLES-1.
REQ-015 GATE: the gate timer SHALL decrement each cycle; busy=1 exactly while in GATE (GATE_CYCLES cycles).
REQ-016 GATE: each cycle with edge_p=1 SHALL increment the working counter; at all-ones it SHALL hold and set ovf.
REQ-017 GATE with timer=0: the FSM SHALL move to DONE, latching count (including an edge_p in that final cycle) and ovf, and set valid=1.
REQ-018 DONE: count, ovf, valid SHALL hold stable until ack=1; ack SHALL clear valid and move to IDLE next cycle.
REQ-019 start SHALL be ignored in GATE and DONE; start and ack together in DONE: ack wins, start dropped.
REQ-020 ack outside DONE SHALL be ignored.
REQ-021 Edges pending in the synchronizer at gate entry/exit SHALL be counted only if edge_p occurs in a GATE cycle (+/-1 count quantisation accepted).

Reset
REQ-022 rst=0 SHALL immediately force IDLE, count=0, valid=0, busy=0, ovf=0, synchronizer flops=0, timers cleared.
REQ-023 Reset mid-GATE or mid-DONE SHALL discard the measurement; no valid pulse follows reset release.
REQ-024 After rst release the first edge_p SHALL not fire unless sig_in shows a genuine 0-to-1 transition after synchronization.

Configuration
REQ-025 Macro FREQ_METER_CONTINUOUS_EN defined: ack in DONE SHALL go directly to GATE (reload timer, clear working counter) with no start needed; continuous measurement.
REQ-026 Macro FREQ_METER_CONTINUOUS_EN undefined: ack in DONE SHALL return to IDLE and a new start is required.

Structure
REQ-027 A package freq_meter_pkg SHALL hold the state enum (IDLE, GATE, DONE) and default GATE_CYCLES/CNT_W constants.
REQ-028 The synchronizer and edge detector SHALL be one sub-module, sync_edge (ports clk, rst, d, pulse).
REQ-029 Gate timer width SHALL be $clog2(GATE_CYCLES); working counter width CNT_W.

Verification
REQ-030 clk 10 ns, GATE_CYCLES=1000, sig_in period 100 ns, start pulse -> busy 1000 cycles, then valid=1, count=100 (+/-1), ovf=0.
REQ-031 sig_in held 0, start -> count=0, valid=1 after 1000 cycles; ack -> valid=0, IDLE.
REQ-032 CNT_W=4, sig_in period 40 ns, GATE_CYCLES=1000 -> count=15, ovf=1.
REQ-033 rst=0 at cycle 500 of GATE -> all outputs 0 immediately; no valid after release without new start.
REQ-034 start asserted during GATE and with ack in DONE -> ignored; exactly one result per start.
REQ-035 With FREQ_METER_CONTINUOUS_EN, ack after first result -> busy=1 next cycle, second valid 1000 cycles later with count=100 (+/-1).
